// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt source controller: register map,
// mode encodings, bus direction encodings and the ID priority helper.
package irq_ctrl_pkg;

  // Word register index on the slave bus.
  typedef enum logic [1:0] {
    REG_PEND   = 2'h0,
    REG_ENABLE = 2'h1,
    REG_MODE   = 2'h2,
    REG_ID     = 2'h3
  } reg_addr_e;

  localparam int   IRQ_CTRL_ADDR_W   = 2;
  localparam logic IRQ_MODE_EDGE     = 1'b1;
  localparam logic IRQ_MODE_LEVEL    = 1'b0;
  localparam int   IRQ_ID_VALID_LOC  = 31;

  // Bus direction on the rw line.
  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  // One decoded bus access for the current cycle.
  typedef struct packed {
    logic      rd;
    logic      wr;
    reg_addr_e addr;
  } bus_req_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// Per-channel input conditioning: a SYNC_STAGES-deep synchroniser for the
// raw asynchronous line, a one-cycle delayed copy, and a rising-edge pulse.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  output logic s_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;

  // Shift the raw line through the synchroniser and keep one cycle of history.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], src_i};
    s_dly_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history flops; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign edge_o = sync_q[SYNC_STAGES-1] & ~s_dly_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt source controller: synchronises peripheral interrupt lines,
// latches them as edge- or level-sensitive pending bits, and exposes
// PEND / ENABLE / MODE / ID to the CPU over the AZPR slave bus.
// irq is the registered AND of pending and enable bits.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cs_,
  input  logic                       as_,
  input  logic                       rw,
  input  logic [IRQ_CTRL_ADDR_W-1:0] addr,
  input  logic [31:0]                wr_data,
  output logic [31:0]                rd_data,
  output logic                       rdy_,
  input  logic [IRQ_CH-1:0]          src,
  output logic [IRQ_CH-1:0]          irq
);

  logic [IRQ_CH-1:0] s_vec;
  logic [IRQ_CH-1:0] edge_vec;

  logic [IRQ_CH-1:0] pend_q,   pend_d;
  logic [IRQ_CH-1:0] enable_q, enable_d;
  logic [IRQ_CH-1:0] mode_q,   mode_d;
  logic [IRQ_CH-1:0] irq_q,    irq_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rdy_q,    rdy_d;

  bus_req_t          req;
  logic [IRQ_CH-1:0] wr_bits;
  logic [IRQ_CH-1:0] pend_en;
  logic [31:0]       id_val;
  logic [31:0]       rd_val;
  logic [IRQ_CH-1:0] w1c_mask;
  logic [IRQ_CH-1:0] mode_chg;
  logic [IRQ_CH-1:0] pend_edge;

  // One synchroniser per interrupt source.
  for (genvar i = 0; i < IRQ_CH; i++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .src_i  (src[i]),
      .s_o    (s_vec[i]),
      .edge_o (edge_vec[i])
    );
  end

  // Register bits above the channel count are never stored.
  if (IRQ_CH < 32) begin : g_unused_wr
    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data[31:IRQ_CH];
  end

  assign wr_bits = wr_data[IRQ_CH-1:0];

  // Decode the strobes into a read or write of one register this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req      = '0;
    req.addr = reg_addr_e'(addr);
    if (!cs_ && !as_) begin
      req.rd = (rw == BUS_READ);
      req.wr = (rw == BUS_WRITE);
    end
  end

  // ID register: valid flag plus the lowest-index enabled pending channel.
  always_comb begin
    pend_en = pend_q & enable_q;
    id_val  = '0;
    if (|pend_en) begin
      id_val[IRQ_ID_VALID_LOC] = 1'b1;
      id_val[4:0]              = lowest_set(32'(pend_en));
    end
  end

  // Read mux on pre-update register values, registered onto the bus.
  always_comb begin
    rd_val = '0;
    unique case (req.addr)
      REG_PEND:   rd_val = 32'(pend_q);
      REG_ENABLE: rd_val = 32'(enable_q);
      REG_MODE:   rd_val = 32'(mode_q);
      REG_ID:     rd_val = id_val;
    endcase
    rd_data_d = req.rd ? rd_val : '0;
    rdy_d     = !(req.rd || req.wr);
  end

  // Pending, enable and mode next-state; a set from an edge beats a W1C clear,
  // and a MODE change clears the affected channels outright.
  always_comb begin
    w1c_mask  = (req.wr && req.addr == REG_PEND) ? wr_bits : '0;
    mode_chg  = (req.wr && req.addr == REG_MODE) ? (wr_bits ^ mode_q) : '0;
    pend_edge = (pend_q & ~w1c_mask) | edge_vec;
    pend_d    = ((pend_edge & mode_q) | (s_vec & ~mode_q)) & ~mode_chg;
    enable_d  = (req.wr && req.addr == REG_ENABLE) ? wr_bits : enable_q;
    mode_d    = (req.wr && req.addr == REG_MODE)   ? wr_bits : mode_q;
    irq_d     = pend_en;
  end

  // Register state; mode resets to all-edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      pend_q    <= '0;
      enable_q  <= '0;
      mode_q    <= {IRQ_CH{IRQ_MODE_EDGE}};
      irq_q     <= '0;
      rd_data_q <= '0;
      rdy_q     <= 1'b1;
    end else begin
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
    end
  end

  assign irq     = irq_q;
  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a cycle-level behavioural model built
// from the register rules, compared against the DUT every cycle, plus
// directed scenarios with hand-computed register values and randomized traffic.
module tb_irq_ctrl;

  localparam int IRQ_CH      = 8;
  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] A_PEND   = 2'h0;
  localparam logic [1:0] A_ENABLE = 2'h1;
  localparam logic [1:0] A_MODE   = 2'h2;
  localparam logic [1:0] A_ID     = 2'h3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs_, as_, rw;
  logic [1:0]        addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              rdy_;
  logic [IRQ_CH-1:0] src;
  logic [IRQ_CH-1:0] irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(
    .IRQ_CH      (IRQ_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .src     (src),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              model_ok = 1'b0;
  logic [IRQ_CH-1:0] m_pend, m_enable, m_mode, m_irq;
  logic [31:0]       m_rd;
  logic              m_rdy;
  logic [IRQ_CH-1:0] s_hist[$];   // s_hist[k] = src sampled k+1 edges ago

  function automatic logic [31:0] model_id(input logic [IRQ_CH-1:0] p, input logic [IRQ_CH-1:0] e);
    for (int i = 0; i < IRQ_CH; i++)
      if (p[i] && e[i]) return 32'h8000_0000 + i;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [IRQ_CH-1:0] o_pend, o_en, o_mode, s_cur, s_prev;
    logic acc, is_rd, is_wr;
    if (!reset) begin
      model_ok = 1'b1;
      m_pend   = '0;
      m_enable = '0;
      m_mode   = '1;
      m_irq    = '0;
      m_rd     = '0;
      m_rdy    = 1'b1;
      s_hist   = {};
      for (int k = 0; k <= SYNC_STAGES; k++) s_hist.push_back('0);
    end else if (model_ok) begin
      o_pend = m_pend; o_en = m_enable; o_mode = m_mode;
      // synchronised level seen this cycle and one cycle earlier
      s_cur  = s_hist[SYNC_STAGES-1];
      s_prev = s_hist[SYNC_STAGES];
      acc    = !cs_ && !as_;
      is_rd  = acc && rw;
      is_wr  = acc && !rw;
      m_rdy  = !acc;
      m_rd   = 32'h0;
      if (is_rd) begin
        case (addr)
          A_PEND:   m_rd = 32'(o_pend);
          A_ENABLE: m_rd = 32'(o_en);
          A_MODE:   m_rd = 32'(o_mode);
          default:  m_rd = model_id(o_pend, o_en);
        endcase
      end
      for (int ch = 0; ch < IRQ_CH; ch++) begin
        if (is_wr && addr == A_MODE && wr_data[ch] != o_mode[ch]) begin
          m_pend[ch] = 1'b0;
        end else if (o_mode[ch]) begin
          if (s_cur[ch] && !s_prev[ch])                       m_pend[ch] = 1'b1;
          else if (is_wr && addr == A_PEND && wr_data[ch])    m_pend[ch] = 1'b0;
        end else begin
          m_pend[ch] = s_cur[ch];
        end
      end
      if (is_wr && addr == A_ENABLE) m_enable = wr_data[IRQ_CH-1:0];
      if (is_wr && addr == A_MODE)   m_mode   = wr_data[IRQ_CH-1:0];
      m_irq = o_pend & o_en;
      s_hist.push_front(src);
      void'(s_hist.pop_back());
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("irq",     32'(irq),  32'(m_irq));
      check("rdy_",    32'(rdy_), 32'(m_rdy));
      check("rd_data", rd_data,   m_rd);
    end
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    tick();
    check("wr_rdy", 32'(rdy_), 32'h0);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    tick();
    check({name, "_rdy"}, 32'(rdy_), 32'h0);
    check(name, rd_data, exp);
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  initial begin
    reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0; src = '0;
    @(posedge clk); tick();
    reset = 1'b1;

    // 1: edge channel 0, 3-cycle pulse, irq four edges after first sample
    bus_write(A_ENABLE, 32'h01);
    bus_write(A_MODE,   32'h01);
    src[0] = 1'b1;
    tick(); tick(); tick();
    src[0] = 1'b0;
    check("t1_irq_e3", 32'(irq[0]), 32'h0);
    tick();
    check("t1_irq_e4", 32'(irq[0]), 32'h1);
    bus_read(A_PEND, 32'h01, "t1_pend");
    bus_read(A_ID,   32'h8000_0000, "t1_id");

    // 2: W1C clears, held-high source sets only once
    bus_write(A_PEND, 32'h01);
    tick();
    check("t2_irq_clr", 32'(irq[0]), 32'h0);
    bus_read(A_PEND, 32'h00, "t2_pend_clr");
    src[0] = 1'b1;
    repeat (5) tick();
    bus_read(A_PEND, 32'h01, "t2_pend_set");
    bus_write(A_PEND, 32'h01);
    repeat (5) tick();
    bus_read(A_PEND, 32'h00, "t2_no_retrig");
    src[0] = 1'b0;
    repeat (3) tick();

    // 3: level channel 2 follows the source, W1C ignored
    bus_write(A_ENABLE, 32'h04);
    src[2] = 1'b1;
    repeat (3) tick();
    check("t3_irq_e3", 32'(irq[2]), 32'h0);
    tick();
    check("t3_irq_e4", 32'(irq[2]), 32'h1);
    repeat (6) tick();
    bus_write(A_PEND, 32'h04);
    bus_read(A_PEND, 32'h04, "t3_w1c_ignored");
    src[2] = 1'b0;
    repeat (3) tick();
    check("t3_irq_hold", 32'(irq[2]), 32'h1);
    tick();
    check("t3_irq_drop", 32'(irq[2]), 32'h0);

    // 4: edge arrives in the same cycle as the W1C -> set wins
    src[0] = 1'b1;
    tick(); tick();
    bus_write(A_PEND, 32'h01);
    bus_read(A_PEND, 32'h01, "t4_set_wins");
    src[0] = 1'b0;
    bus_write(A_PEND, 32'h01);

    // 5: ID priority among enabled pending channels
    bus_write(A_MODE, 32'h29);
    src[3] = 1'b1; src[5] = 1'b1;
    repeat (4) tick();
    bus_write(A_ENABLE, 32'h20);
    bus_read(A_PEND, 32'h28, "t5_pend");
    bus_read(A_ID, 32'h8000_0005, "t5_id5");
    bus_write(A_ENABLE, 32'h28);
    bus_read(A_ID, 32'h8000_0003, "t5_id3");
    bus_write(A_ENABLE, 32'h00);
    bus_read(A_ID, 32'h0, "t5_id0");
    check("t5_irq0", 32'(irq), 32'h0);
    src = '0;

    // 6: reset during a read aborts it; back-to-back reads each acknowledged
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = A_PEND; reset = 1'b0;
    tick();
    check("t6_rst_rdy", 32'(rdy_), 32'h1);
    check("t6_rst_rd",  rd_data,   32'h0);
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1;
    bus_read(A_PEND,   32'h00, "t6_pend");
    bus_read(A_ENABLE, 32'h00, "t6_enable");
    bus_read(A_MODE,   32'hFF, "t6_mode");
    bus_read(A_ID,     32'h00, "t6_id");
    tick();
    check("t6_rdy_idle", 32'(rdy_), 32'h1);

    // Randomized traffic checked by the per-cycle model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < IRQ_CH; b++)
        if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
      if ($urandom_range(0, 3) == 0) begin
        cs_ = 1'b1; as_ = 1'b1;
      end else begin
        cs_ = 1'b0; as_ = 1'b0;
        rw      = ($urandom_range(0, 2) != 0);
        addr    = 2'($urandom_range(0, 3));
        wr_data = $urandom;
        if (!rw && addr == A_MODE && $urandom_range(0, 1) == 0) wr_data[7:0] = dut.mode_q ^ 8'(1 << $urandom_range(0, 7));
      end
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
